// File: rtl/decode_stage.sv
// Registered RV32I decode stage. It turns a fetched instruction into ALU op, operand selects,
// immediate, register indices and control flags, with one-entry valid/ready buffering.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [3:0]      alu_op,
    output logic [1:0]      a_sel,
    output logic            b_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_wr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      funct3_out,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;

    localparam logic [1:0] ASEL_RS1  = 2'b00;
    localparam logic [1:0] ASEL_PC   = 2'b01;
    localparam logic [1:0] ASEL_ZERO = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic [1:0]      a_sel;
        logic            b_imm;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_wr;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } bundle_t;

    bundle_t bundle_reg;
    bundle_t bundle_next;
    logic    out_valid_reg;
    logic    load;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Replicated sign bit shared by every sign-extended immediate format.
    logic [XLEN-13:0] sign_fill;
    genvar gi;
    generate
        for (gi = 0; gi < XLEN - 12; gi++) begin : g_sign_fill
            assign sign_fill[gi] = instr[31];
        end
    endgenerate

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;
    assign imm_i     = {sign_fill, instr[31:20]};
    assign imm_s     = {sign_fill, instr[31:25], instr[11:7]};
    assign imm_b     = {sign_fill[XLEN-14:0], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {sign_fill[XLEN-22:0], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};

    logic [3:0] arith_op;
    always_comb begin
        arith_op = ALU_ADD;
        case (f3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    logic use_rs1, use_rs2, use_rd, bad;
    always_comb begin
        bundle_next        = '0;
        bundle_next.pc     = pc_in;
        bundle_next.alu_op = ALU_ADD;
        bundle_next.a_sel  = ASEL_RS1;
        use_rs1            = 1'b0;
        use_rs2            = 1'b0;
        use_rd             = 1'b0;
        bad                = (instr[1:0] != 2'b11);
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                bundle_next.alu_op = arith_op;
                if (f7 == F7_ALT && f3 == 3'b000)      bundle_next.alu_op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) bundle_next.alu_op = ALU_SRA;
                else if (f7 != F7_ZERO)                bad = 1'b1;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                bundle_next.b_imm  = 1'b1;
                bundle_next.alu_op = arith_op;
                bundle_next.imm    = imm_i;
                if (f3 == 3'b001) begin
                    bundle_next.imm = imm_shamt;
                    if (f7 != F7_ZERO) bad = 1'b1;
                end else if (f3 == 3'b101) begin
                    bundle_next.imm = imm_shamt;
                    if (f7 == F7_ALT)        bundle_next.alu_op = ALU_SRA;
                    else if (f7 != F7_ZERO)  bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                bundle_next.b_imm  = 1'b1;
                bundle_next.imm    = imm_i;
                bundle_next.mem_rd = 1'b1;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) bad = 1'b1;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bundle_next.b_imm  = 1'b1;
                bundle_next.imm    = imm_s;
                bundle_next.mem_wr = 1'b1;
                if (f3[2] || f3 == 3'b011) bad = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bundle_next.imm    = imm_b;
                bundle_next.branch = 1'b1;
                case (f3[2:1])
                    2'b00:   bundle_next.alu_op = ALU_SUB;
                    2'b10:   bundle_next.alu_op = ALU_SLT;
                    2'b11:   bundle_next.alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                bundle_next.a_sel = ASEL_PC;
                bundle_next.b_imm = 1'b1;
                bundle_next.imm   = imm_j;
                bundle_next.jump  = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                bundle_next.b_imm = 1'b1;
                bundle_next.imm   = imm_i;
                bundle_next.jump  = 1'b1;
                if (f3 != 3'b000) bad = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1;
                bundle_next.a_sel = (opcode == OPC_LUI) ? ASEL_ZERO : ASEL_PC;
                bundle_next.b_imm = 1'b1;
                bundle_next.imm   = imm_u;
            end
            default: bad = 1'b1;
        endcase

        bundle_next.rs1    = use_rs1 ? instr[19:15] : 5'd0;
        bundle_next.rs2    = use_rs2 ? instr[24:20] : 5'd0;
        bundle_next.rd     = use_rd  ? instr[11:7]  : 5'd0;
        bundle_next.reg_wr = use_rd && (instr[11:7] != 5'd0);
        bundle_next.funct3 = f3;

        // Illegal encodings still issue, but carry nothing that could act on state.
        if (bad) begin
            bundle_next         = '0;
            bundle_next.pc      = pc_in;
            bundle_next.illegal = 1'b1;
        end
    end

    assign in_ready = !out_valid_reg || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            bundle_reg    <= '0;
        end else begin
            if (flush)          out_valid_reg <= 1'b0;
            else if (load)      out_valid_reg <= 1'b1;
            else if (out_ready) out_valid_reg <= 1'b0;
            if (load) bundle_reg <= bundle_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign pc_out     = bundle_reg.pc;
    assign alu_op     = bundle_reg.alu_op;
    assign a_sel      = bundle_reg.a_sel;
    assign b_imm      = bundle_reg.b_imm;
    assign imm        = bundle_reg.imm;
    assign rs1        = bundle_reg.rs1;
    assign rs2        = bundle_reg.rs2;
    assign rd         = bundle_reg.rd;
    assign reg_wr     = bundle_reg.reg_wr;
    assign mem_rd     = bundle_reg.mem_rd;
    assign mem_wr     = bundle_reg.mem_wr;
    assign branch     = bundle_reg.branch;
    assign jump       = bundle_reg.jump;
    assign funct3_out = bundle_reg.funct3;
    assign illegal    = bundle_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: spec vector table, handshake corner sequences,
// and randomized traffic against an instruction-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc_in = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] pc_out, imm;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_wr, mem_rd, mem_wr, branch, jump, illegal;
    logic [2:0]  funct3_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .alu_op(alu_op), .a_sel(a_sel), .b_imm(b_imm), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump),
        .funct3_out(funct3_out), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_imm;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        reg_wr, mem_rd, mem_wr, branch, jump;
        logic [2:0]  funct3;
        logic        illegal;
    } bundle_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  op;
        logic [4:0]  r1, r2, rdst;
        logic [31:0] im;
        logic [1:0]  asel;
        logic        bimm, wr, ill;
    } vec_t;

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b = '{pc_out, alu_op, a_sel, b_imm, imm, rs1, rs2, rd,
              reg_wr, mem_rd, mem_wr, branch, jump, funct3_out, illegal};
        return b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level model: classify by opcode, build immediates arithmetically.
    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        bundle_t     b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok, has_rs1, has_rs2, has_rd;
        logic [31:0] sx, t;
        logic [3:0]  arith [8];
        arith = '{4'd0, 4'd4, 4'd2, 4'd3, 4'd9, 4'd5, 4'd8, 4'd7};
        b = '0;
        b.pc = pc;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 1'b1; has_rs1 = 1'b0; has_rs2 = 1'b0; has_rd = 1'b0;
        sx = {32{i[31]}};
        case (i[6:0])
            7'h33: begin
                has_rs1 = 1; has_rs2 = 1; has_rd = 1;
                b.alu_op = arith[f3];
                if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) b.alu_op = b.alu_op + 4'd1;
                else if (f7 != 0) ok = 0;
            end
            7'h13: begin
                has_rs1 = 1; has_rd = 1; b.b_imm = 1;
                b.alu_op = arith[f3];
                b.imm = $signed(i) >>> 20;
                if (f3 == 1 || f3 == 5) begin
                    b.imm = 32'(i[24:20]);
                    if (f3 == 5 && f7 == 7'h20) b.alu_op = 4'd6;
                    else if (f7 != 0) ok = 0;
                end
            end
            7'h03: begin
                has_rs1 = 1; has_rd = 1; b.b_imm = 1; b.mem_rd = 1;
                b.imm = $signed(i) >>> 20;
                ok = !(f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin
                has_rs1 = 1; has_rs2 = 1; b.b_imm = 1; b.mem_wr = 1;
                t = $signed(i) >>> 25;
                b.imm = (t << 5) | 32'(i[11:7]);
                ok = (f3 <= 2);
            end
            7'h63: begin
                has_rs1 = 1; has_rs2 = 1; b.branch = 1;
                b.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                b.alu_op = f3[2] ? 4'd2 + 4'(f3[1]) : 4'd1;
                ok = !(f3 == 2 || f3 == 3);
            end
            7'h6F: begin
                has_rd = 1; b.jump = 1; b.a_sel = 2'b01; b.b_imm = 1;
                b.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin
                has_rs1 = 1; has_rd = 1; b.jump = 1; b.b_imm = 1;
                b.imm = $signed(i) >>> 20;
                ok = (f3 == 0);
            end
            7'h37, 7'h17: begin
                has_rd = 1; b.b_imm = 1;
                b.a_sel = (i[6:0] == 7'h37) ? 2'b10 : 2'b01;
                b.imm = i & 32'hFFFFF000;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            b = '0;
            b.pc = pc;
            b.illegal = 1;
            return b;
        end
        b.rs1    = has_rs1 ? i[19:15] : 5'd0;
        b.rs2    = has_rs2 ? i[24:20] : 5'd0;
        b.rd     = has_rd ? i[11:7] : 5'd0;
        b.reg_wr = has_rd && (i[11:7] != 0);
        b.funct3 = f3;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h6F;
            6: r[6:0] = 7'h67;  7: r[6:0] = 7'h37;  8: r[6:0] = 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1; instr = ins; pc_in = pc; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    vec_t    vecs [13];
    bundle_t zero_b;
    bundle_t exp_b;
    logic    exp_valid;
    logic    take;
    logic [31:0] ri;

    initial begin
        zero_b = '0;
        //          instr          op    rs1   rs2   rd    imm           asel   bimm  wr    ill
        vecs[0]  = '{32'h002081B3, 4'd0, 5'd1, 5'd2, 5'd3, 32'h00000000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h407302B3, 4'd1, 5'd6, 5'd7, 5'd5, 32'h00000000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h4040D093, 4'd6, 5'd1, 5'd0, 5'd1, 32'h00000004, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h123450B7, 4'd0, 5'd0, 5'd0, 5'd1, 32'h12345000, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000000, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'hFFC12283, 4'd0, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h0060A423, 4'd0, 5'd1, 5'd6, 5'd0, 32'h00000008, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'hFE208CE3, 4'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000006F, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h002081B1, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h022081B3, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h0020A063, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'h40109093, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1};

        // Reset state
        #12;
        check("reset_valid", 128'(out_valid), 128'(1'b0));
        check("reset_bundle", 128'(dut_bundle()), 128'(zero_b));
        check("reset_in_ready", 128'(in_ready), 128'(1'b1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Spec vector table
        for (int v = 0; v < 13; v++) begin
            issue(vecs[v].ins, 32'h1000 + 32'(v * 4));
            $display("vec %0d instr=%h alu_op=%0d rd=%0d imm=%h illegal=%0d",
                     v, vecs[v].ins, alu_op, rd, imm, illegal);
            check($sformatf("vec%0d_valid", v), 128'(out_valid), 128'(1'b1));
            check($sformatf("vec%0d_fields", v),
                  128'({alu_op, rs1, rs2, rd, imm, a_sel, b_imm, reg_wr, illegal}),
                  128'({vecs[v].op, vecs[v].r1, vecs[v].r2, vecs[v].rdst, vecs[v].im,
                        vecs[v].asel, vecs[v].bimm, vecs[v].wr, vecs[v].ill}));
            check($sformatf("vec%0d_bundle", v), 128'(dut_bundle()),
                  128'(ref_decode(vecs[v].ins, 32'h1000 + 32'(v * 4))));
        end

        // Backpressure: bundle frozen while out_ready is low
        issue(32'h002081B3, 32'h200);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h407302B3; pc_in = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
            @(posedge clk); #1;
            check("bp_valid", 128'(out_valid), 128'(1'b1));
            check("bp_hold", 128'(dut_bundle()), 128'(ref_decode(32'h002081B3, 32'h200)));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("backpressure release instr=%h alu_op=%0d rd=%0d", 32'h407302B3, alu_op, rd);
        check("bp_next_valid", 128'(out_valid), 128'(1'b1));
        check("bp_next_bundle", 128'(dut_bundle()), 128'(ref_decode(32'h407302B3, 32'h204)));

        // Flush together with an incoming instruction
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h123450B7; pc_in = 32'h300; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        $display("flush applied out_valid=%0d", out_valid);
        check("flush_valid", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        check("flush_dropped", 128'(out_valid), 128'(1'b0));

        // Asynchronous reset in the middle of a cycle
        issue(32'h4040D093, 32'h400);
        check("pre_rst_valid", 128'(out_valid), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(1'b0));
        check("async_rst_bundle", 128'(dut_bundle()), 128'(zero_b));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h123450B7, 32'h500);
        $display("post reset instr=%h imm=%h a_sel=%0d", 32'h123450B7, imm, a_sel);
        check("post_rst_valid", 128'(out_valid), 128'(1'b1));
        check("post_rst_bundle", 128'(dut_bundle()), 128'(ref_decode(32'h123450B7, 32'h500)));

        // Randomized traffic against the scoreboard
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        exp_b = '0;
        for (int c = 0; c < 500; c++) begin
            ri        = rand_instr();
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = ri;
            pc_in     = $urandom & 32'hFFFFFFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            check("rand_in_ready", 128'(in_ready), 128'(!exp_valid || out_ready));
            take = in_valid && (!exp_valid || out_ready) && !flush;
            if (exp_valid && out_ready && !flush)
                $display("rand txn %0d pc=%h alu_op=%0d illegal=%0d", c, exp_b.pc, exp_b.alu_op, exp_b.illegal);
            if (flush)          exp_valid = 1'b0;
            else if (take)      begin exp_valid = 1'b1; exp_b = ref_decode(ri, pc_in); end
            else if (out_ready) exp_valid = 1'b0;
            @(posedge clk); #1;
            check("rand_valid", 128'(out_valid), 128'(exp_valid));
            if (exp_valid) check("rand_bundle", 128'(dut_bundle()), 128'(exp_b));
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
